muldiv_seq: RTL
===============

MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: operand width and HI/LO width; even, 8..64.
REQ-002 The block SHALL have parameter STEPS_PER_CYCLE, default 1: iterations per clock; 1, 2 or 4; must divide WIDTH.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port flush, input, 1 bit: abort the in-flight operation.
REQ-006 The block SHALL have port start, input, 1 bit: request a new operation; accepted only when ready=1.
REQ-007 The block SHALL have port ready, output, 1 bit: idle and able to accept start.
REQ-008 The block SHALL have port op, input, muldiv_op_t (2 bits): MUL, DIV, MADD, MSUB.
REQ-009 The block SHALL have port sign, input, 1 bit: signed operation when 1.
REQ-010 The block SHALL have ports src_a and src_b, input, WIDTH each: multiplicand/dividend and multiplier/divisor.
REQ-011 The block SHALL have port done, output, 1 bit: result valid, held until ack.
REQ-012 The block SHALL have port ack, input, 1 bit: consumer accepts the result.
REQ-013 The block SHALL have port div_zero, output, 1 bit: the last DIV had divisor 0; valid while done=1.
REQ-014 The block SHALL have ports hi and lo, output, WIDTH each: architectural HI/LO registers.
REQ-015 The block SHALL have ports hi_we/hi_wdata and lo_we/lo_wdata, input, 1 bit/WIDTH each: direct HI/LO writes (MTHI/MTLO).

Function
REQ-016 The FSM SHALL have states IDLE, BUSY and DONE; ready SHALL equal (state==IDLE).
REQ-017 IDLE with start=1 SHALL latch the operands, the sign-corrected magnitudes, op and sign, load the counter with WIDTH/STEPS_PER_CYCLE, and go to BUSY.
REQ-018 BUSY SHALL decrement the counter each cycle; at 0 it SHALL write HI/LO and go to DONE; start-to-done latency SHALL be WIDTH/STEPS_PER_CYCLE+1 cycles.
REQ-019 MUL SHALL give {hi,lo} = full 2*WIDTH product, signed or unsigned per sign.
REQ-020 DIV SHALL give lo = quotient truncated toward zero and hi = remainder with the sign of the dividend (when sign=1).
REQ-021 DIV with src_b=0 SHALL give lo = all ones, hi = src_a and div_zero=1, with unchanged latency.
REQ-022 Signed DIV of MIN by -1 SHALL give lo = MIN and hi = 0.
REQ-023 DONE SHALL hold done=1 until ack=1, then return to IDLE on the next edge; ack outside DONE SHALL be ignored.
REQ-024 hi_we and lo_we SHALL both take effect in the same cycle when asserted together, in any state.
REQ-025 If a result write-back and hi_we/lo_we fall in the same cycle, the result write SHALL win.
REQ-026 flush SHALL force IDLE from any state and drop done; hi/lo SHALL stay as they were unless hi_we/lo_we is asserted.
REQ-027 flush together with start SHALL not start an operation.

Reset
REQ-028 rst=0 SHALL immediately set state=IDLE, hi=0, lo=0, done=0, div_zero=0 and counter=0, including mid-operation.
REQ-029 After rst rises, ready SHALL be 1 on the first edge.

Configuration
REQ-030 With macro MULDIV_ACCUM_EN defined, MADD SHALL give {hi,lo} += product and MSUB SHALL give {hi,lo} -= product, with MUL latency plus one cycle.
REQ-031 Without MULDIV_ACCUM_EN, MADD and MSUB SHALL execute as MUL and the accumulator adder SHALL not be synthesised.

Structure
REQ-032 muldiv_op_t and the FSM state enum SHALL live in the shared includes package.
REQ-033 One sub-module, muldiv_step, SHALL be combinational: one shift-add step or one restoring-divide step, instantiated STEPS_PER_CYCLE times in a chain.

Verification (WIDTH=32, STEPS_PER_CYCLE=1 unless stated)
REQ-034 MUL sign=1, 0xFFFFFFFF x 0x00000002 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE, done 33 cycles after start.
REQ-035 DIV sign=1, -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; then DIV 5/0 -> lo=0xFFFFFFFF, hi=5, div_zero=1.
REQ-036 DIV sign=1, 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0; unsigned 0xFFFFFFFF / 0x10 -> lo=0x0FFFFFFF, hi=0xF.
REQ-037 Start MUL, flush on cycle 10 -> ready=1 next cycle, hi/lo unchanged; rst=0 mid-DIV -> immediate IDLE, hi=lo=0.
REQ-038 hi_we=1 (0x1234) and lo_we=1 (0x5678) in the same cycle -> hi=0x1234 and lo=0x5678; done held 5 cycles without ack and no second start is accepted.
REQ-039 With STEPS_PER_CYCLE=4 and MULDIV_ACCUM_EN: {hi,lo}=10, MADD 3x4 -> lo=22 with latency 10; MSUB 3x4 -> lo=10.

Source files
------------

// File: rtl/muldiv_seq_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_seq_pkg
//
// Purpose: shared types for the sequential multiply/divide unit.
//   muldiv_op_t    - operation select on the op port (MUL, DIV, MADD, MSUB)
//   muldiv_state_t - control FSM state, also exported on the debug port
//   op_is_accum()  - true for the accumulating operations (MADD/MSUB)
//
// No ports (package).
// -----------------------------------------------------------------------------
package muldiv_seq_pkg;

    typedef enum logic [1:0] {
        OP_MUL  = 2'd0,
        OP_DIV  = 2'd1,
        OP_MADD = 2'd2,
        OP_MSUB = 2'd3
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } muldiv_state_t;

    function automatic logic op_is_accum(input muldiv_op_t op_i);
        return (op_i == OP_MADD) || (op_i == OP_MSUB);
    endfunction

endpackage : muldiv_seq_pkg

// File: rtl/muldiv_step.sv
// -----------------------------------------------------------------------------
// muldiv_step
//
// Purpose: one purely combinational iteration of the shared datapath.
//   i_div = 0 : one shift-add multiply step. {hi,lo} holds the partial
//               product in hi and the remaining multiplier bits in lo; the
//               multiplicand is added to hi when lo[0] is set, then the
//               whole {carry,hi,lo} is shifted right by one.
//   i_div = 1 : one restoring-divide step. hi holds the partial remainder,
//               lo the dividend bits still to be consumed (quotient bits are
//               shifted in at the bottom). {hi,lo} shifts left by one, and
//               the divisor is subtracted when it fits.
//
// Ports:
//   i_div      - step type select (0 multiply, 1 divide)
//   i_hi, i_lo - working register halves entering this step
//   i_operand  - multiplicand magnitude (multiply) or divisor magnitude
//   o_hi, o_lo - working register halves after this step
// -----------------------------------------------------------------------------
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             i_div,
    input  logic [WIDTH-1:0] i_hi,
    input  logic [WIDTH-1:0] i_lo,
    input  logic [WIDTH-1:0] i_operand,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    logic [WIDTH:0]   w_add_sum;
    logic [WIDTH:0]   w_shift_rem;
    logic [WIDTH-1:0] w_sub_diff;
    logic             w_fits;

    always_comb begin
        // Multiply: the extra top bit keeps the carry of the add.
        w_add_sum   = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_operand} : '0);

        // Divide: the shifted remainder can reach 2*divisor-1, so compare
        // on WIDTH+1 bits. When it fits, the true difference is below the
        // divisor, so a WIDTH-bit modular subtract is exact.
        w_shift_rem = {i_hi, i_lo[WIDTH-1]};
        w_fits      = (w_shift_rem >= {1'b0, i_operand});
        w_sub_diff  = w_shift_rem[WIDTH-1:0] - i_operand;

        if (i_div) begin
            o_hi = w_fits ? w_sub_diff : w_shift_rem[WIDTH-1:0];
            o_lo = {i_lo[WIDTH-2:0], w_fits};
        end else begin
            o_hi = w_add_sum[WIDTH:1];
            o_lo = {w_add_sum[0], i_lo[WIDTH-1:1]};
        end
    end

endmodule : muldiv_step

// File: rtl/muldiv_seq.sv
// -----------------------------------------------------------------------------
// muldiv_seq
//
// Purpose: iterative multiply/divide unit with architectural HI/LO registers
// (MIPS-style). Operands are converted to magnitudes at start, WIDTH
// iterations of muldiv_step run (STEPS_PER_CYCLE per clock), and the sign is
// re-applied at write-back.
//
// Configuration: macro MULDIV_ACCUM_EN enables MADD/MSUB ({hi,lo} +/- product,
// one extra cycle). Without it MADD/MSUB behave exactly as MUL and no
// accumulator adder exists.
//
// Handshake: start is accepted on an edge where ready=1 and flush=0. done
// stays high from write-back until an edge with ack=1; ack in any other state
// has no effect. flush returns to IDLE from any state without touching HI/LO.
//
// Ports:
//   clk, rst              - clock, asynchronous active-low reset
//   flush                 - abort in-flight operation
//   start, ready          - request / idle indication
//   op, sign              - operation and signedness
//   src_a, src_b          - multiplicand/dividend, multiplier/divisor
//   done, ack             - result valid / consumer accept
//   div_zero              - last DIV had a zero divisor (valid with done)
//   hi, lo                - architectural HI/LO
//   hi_we/hi_wdata,
//   lo_we/lo_wdata        - direct HI/LO writes (MTHI/MTLO)
//   o_dbg_state           - current control state
// -----------------------------------------------------------------------------
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int WIDTH           = 32,
    parameter int STEPS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             start,
    output logic             ready,
    input  muldiv_op_t       op,
    input  logic             sign,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             done,
    input  logic             ack,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    input  logic             hi_we,
    input  logic [WIDTH-1:0] hi_wdata,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] lo_wdata,
    output muldiv_state_t    o_dbg_state
);

    localparam int ITERS = WIDTH / STEPS_PER_CYCLE;
    localparam int CNT_W = $clog2(ITERS + 1);

    // ---------------------------------------------------------------- state
    muldiv_state_t    r_state;
    muldiv_state_t    w_state_next;

    logic [CNT_W-1:0] r_cnt;
    muldiv_op_t       r_op;
    logic             r_a_neg;
    logic             r_b_neg;
    logic             r_b_zero;
    logic             r_acc_ph;      // accumulate cycle already armed
    logic [WIDTH-1:0] r_src_a;       // raw dividend, returned in HI on /0
    logic [WIDTH-1:0] r_operand;     // multiplicand or divisor magnitude
    logic [WIDTH-1:0] r_work_hi;
    logic [WIDTH-1:0] r_work_lo;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_div_zero;

    // ------------------------------------------------------------- controls
    logic             w_start_ok;
    logic             w_iterate;
    logic             w_writeback;
    logic             w_acc_arm;
    logic             w_is_div;
    logic             w_is_accum;

    // ------------------------------------------------------ operand prepare
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;

    assign w_a_neg = sign & src_a[WIDTH-1];
    assign w_b_neg = sign & src_b[WIDTH-1];
    // The magnitude of MIN is 2**(WIDTH-1), which still fits unsigned.
    assign w_a_mag = w_a_neg ? -src_a : src_a;
    assign w_b_mag = w_b_neg ? -src_b : src_b;

    assign w_is_div = (r_op == OP_DIV);

`ifdef MULDIV_ACCUM_EN
    assign w_is_accum = op_is_accum(r_op);
`else
    assign w_is_accum = 1'b0;
`endif

    // ------------------------------------------------------- step chaining
    logic [WIDTH-1:0] w_chain_hi [0:STEPS_PER_CYCLE];
    logic [WIDTH-1:0] w_chain_lo [0:STEPS_PER_CYCLE];

    assign w_chain_hi[0] = r_work_hi;
    assign w_chain_lo[0] = r_work_lo;

    for (genvar g = 0; g < STEPS_PER_CYCLE; g++) begin : g_step
        muldiv_step #(
            .WIDTH(WIDTH)
        ) u_step (
            .i_div    (w_is_div),
            .i_hi     (w_chain_hi[g]),
            .i_lo     (w_chain_lo[g]),
            .i_operand(r_operand),
            .o_hi     (w_chain_hi[g+1]),
            .o_lo     (w_chain_lo[g+1])
        );
    end

    // ------------------------------------------------------ result shaping
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_s;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_wb_hi;
    logic [WIDTH-1:0]   w_wb_lo;
    logic               w_wb_dz;

    assign w_prod   = {r_work_hi, r_work_lo};
    assign w_prod_s = (r_a_neg ^ r_b_neg) ? -w_prod : w_prod;
    // Quotient truncates toward zero; remainder follows the dividend sign.
    // MIN / -1 falls out naturally: magnitude 2**(WIDTH-1) negates to MIN.
    assign w_quot   = (r_a_neg ^ r_b_neg) ? -r_work_lo : r_work_lo;
    assign w_rem    = r_a_neg ? -r_work_hi : r_work_hi;

`ifdef MULDIV_ACCUM_EN
    logic [2*WIDTH-1:0] w_acc_sum;
    assign w_acc_sum = (r_op == OP_MSUB) ? ({r_hi, r_lo} - w_prod_s)
                                         : ({r_hi, r_lo} + w_prod_s);
`endif

    always_comb begin
        w_wb_dz            = 1'b0;
        {w_wb_hi, w_wb_lo} = w_prod_s;
        if (w_is_div) begin
            if (r_b_zero) begin
                // The divide still runs its full length; only the result
                // is replaced.
                w_wb_hi = r_src_a;
                w_wb_lo = '1;
                w_wb_dz = 1'b1;
            end else begin
                w_wb_hi = w_rem;
                w_wb_lo = w_quot;
            end
        end
`ifdef MULDIV_ACCUM_EN
        if (w_is_accum) begin
            {w_wb_hi, w_wb_lo} = w_acc_sum;
        end
`endif
    end

    // ----------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_iterate    = 1'b0;
        w_writeback  = 1'b0;
        w_acc_arm    = 1'b0;
        ready        = (r_state == ST_IDLE);
        done         = (r_state == ST_DONE);
        if (flush) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_state_next = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (r_cnt != '0) begin
                        w_iterate = 1'b1;
                    end else if (w_is_accum && !r_acc_ph) begin
                        // Product is final; spend one more cycle before
                        // folding it into HI/LO.
                        w_acc_arm = 1'b1;
                    end else begin
                        w_writeback  = 1'b1;
                        w_state_next = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (ack) begin
                        w_state_next = ST_IDLE;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    assign w_start_ok = (r_state == ST_IDLE) && start && !flush;

    // ------------------------------------------------------------ datapath
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt      <= '0;
            r_op       <= OP_MUL;
            r_a_neg    <= 1'b0;
            r_b_neg    <= 1'b0;
            r_b_zero   <= 1'b0;
            r_acc_ph   <= 1'b0;
            r_src_a    <= '0;
            r_operand  <= '0;
            r_work_hi  <= '0;
            r_work_lo  <= '0;
        end else begin
            if (w_start_ok) begin
                r_cnt     <= CNT_W'(ITERS);
                r_op      <= op;
                r_a_neg   <= w_a_neg;
                r_b_neg   <= w_b_neg;
                r_b_zero  <= (src_b == '0);
                r_acc_ph  <= 1'b0;
                r_src_a   <= src_a;
                r_work_hi <= '0;
                if (op == OP_DIV) begin
                    r_operand <= w_b_mag;
                    r_work_lo <= w_a_mag;
                end else begin
                    r_operand <= w_a_mag;
                    r_work_lo <= w_b_mag;
                end
            end else if (w_iterate) begin
                r_cnt     <= r_cnt - CNT_W'(1);
                r_work_hi <= w_chain_hi[STEPS_PER_CYCLE];
                r_work_lo <= w_chain_lo[STEPS_PER_CYCLE];
            end
            if (w_acc_arm) begin
                r_acc_ph <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------- HI / LO
    // A result write-back takes priority over MTHI/MTLO in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hi       <= '0;
            r_lo       <= '0;
            r_div_zero <= 1'b0;
        end else begin
            if (w_writeback) begin
                r_hi       <= w_wb_hi;
                r_lo       <= w_wb_lo;
                r_div_zero <= w_wb_dz;
            end else begin
                if (hi_we) begin
                    r_hi <= hi_wdata;
                end
                if (lo_we) begin
                    r_lo <= lo_wdata;
                end
            end
        end
    end

    assign hi          = r_hi;
    assign lo          = r_lo;
    assign div_zero    = r_div_zero;
    assign o_dbg_state = r_state;

endmodule : muldiv_seq
